sqr_iter: RTL and testbench
===========================

# sqr_iter

Parametrised, iterative shift-and-add squarer/multiplier with valid/ready handshakes on both sides. Processes one multiplier bit per clock. Squares a W-bit operand, or multiplies two W-bit operands, into a full 2W-bit product with no truncation. Sits in the arithmetic datapath wherever a squared magnitude or small product is needed without a single-cycle array multiplier.

## Interface
- W, default 10: operand width in bits; W ≥ 2.
- CW, default $clog2(W+1): iteration counter width (derived, not overridden).
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- mul_mode  in  1  0 = square a; 1 = a × b. Sampled only at accept.
- a  in  W  unsigned multiplicand.
- b  in  W  unsigned multiplier; ignored when mul_mode = 0.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer takes the product.
- product  out  2W  unsigned result.
- busy  out  1  high in CALC and DONE.

## Operation
- States:
  - IDLE: in_ready = 1.
  - CALC: iterating.
  - DONE: out_valid = 1.
- Accept: in_valid && in_ready at an edge. At that edge, latch:
  - mcand = zero-extended a (2W bits).
  - mplier = mul_mode ? b : a.
  - acc = 0.
  - cnt = 0.
  - Go to CALC, except as given under Configuration.
- CALC step, each edge:
  - If mplier[0], acc ← acc + mcand.
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt + 1.
  - Go to DONE at the edge where cnt reaches W.
- Arithmetic: all sums are 2W bits wide. W shifts of mcand never lose bits, so overflow is impossible.
- DONE:
  - product = acc, held stable.
  - in_ready = 0; in_valid is ignored.
  - out_valid && out_ready at an edge → IDLE.
- product reads acc in every state. It is defined only while out_valid = 1.
- Changes on a, b and mul_mode after accept have no effect.
- Reset, effective at any edge in any state, including mid-CALC and while DONE is waiting on out_ready:
  - State → IDLE; acc, mcand, mplier and cnt → 0.
  - The in-flight operation is dropped.
  - While rst is high, in_ready = 0 and out_valid = 0.
- Output values after reset: in_ready = 1, out_valid = 0, busy = 0, product = 0.

## Timing
- All outputs decode from registered state and registers only. There are no combinational paths from inputs to outputs.
- Latency, fixed build: out_valid rises after the W-th edge following the accept edge, i.e. W+1 edges after the accept edge is registered.
- Issue interval, with out_ready held high: W+2 cycles per operation.
- No accept occurs in the same cycle as the DONE → IDLE handoff. in_ready rises the cycle after the product is taken.
- Backpressure: DONE holds indefinitely; product and out_valid stay stable.

## Configuration
- Macro: SQR_ITER_EARLY_EXIT_EN.
- Defined:
  - CALC also exits at the edge where the post-shift mplier equals 0.
  - If the latched multiplier is 0, the accept edge goes directly to DONE with acc = 0.
  - Cycle count k = bit length of the multiplier, range 0..W.
  - out_valid rises after edge k following the accept edge; k = 0 means the accept edge itself.
- Undefined: always exactly W CALC cycles, giving data-independent latency.
- product values are identical in both builds.

## Structure
- Shared package sqr_pkg holds:
  - typedef enum state_t {IDLE, CALC, DONE}.
  - A localparam default width of 10.
  - A function sqr_ref(a, b, mode) used by the bench.
- One combinational sub-module, shift_add_step, computes the next acc/mcand/mplier values from the current ones. sqr_iter holds the FSM, counter and registers.

## Test plan
1. W=10, fixed build, a=1023, mul_mode=0 → product = 1046529. out_valid rises exactly 11 edges after the accept edge.
2. Early-exit build, a=1000, b=3, mul_mode=1 → product = 3000, out_valid after 2 iterations. The same stimulus in the fixed build takes 10 iterations with an identical product.
3. a=0, mul_mode=0 → product = 0. Early-exit build: DONE in the cycle after the accept edge. Fixed build: after 10 iterations.
4. Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → product and out_valid stable, in_ready = 0, no second accept. Release → IDLE, then the new operands are accepted.
5. Assert rst for 1 cycle at iteration 4 of a=511 → next cycle out_valid = 0, in_ready = 1, busy = 0. A following a=3 square returns 9.
6. 1000 back-to-back random (a, b, mode) operations with random out_ready stalls, W ∈ {4, 10, 16} → every product equals sqr_ref, with no lost or duplicated transactions.

Source files
------------

// File: rtl/sqr_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sqr_pkg
// Purpose  : Shared types, default width and a reference product function
//            for the iterative shift-and-add squarer/multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package sqr_pkg;

  localparam int SQR_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-precision product: a*a when mode is 0, a*b when mode is 1.
  function automatic logic [63:0] sqr_ref(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        mode);
    logic [63:0] x;
    logic [63:0] y;
    x = {32'd0, a};
    y = mode ? {32'd0, b} : {32'd0, a};
    return x * y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqr_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : sqr_iter_if
// Purpose  : Operand request and product response handshakes of sqr_iter.
//            master = requester/consumer side, slave = the squarer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface sqr_iter_if
  import sqr_pkg::*;
#(
  parameter int W = SQR_W_DEFAULT
);

  logic           in_valid;
  logic           in_ready;
  logic           mul_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  modport master (
    output in_valid, mul_mode, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, mul_mode, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface
`default_nettype wire

// File: rtl/sqr_iter_shift_add_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_step
// Purpose  : One shift-and-add iteration: conditionally add the multiplicand
//            into the accumulator, then shift multiplicand left and
//            multiplier right. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_step
  import sqr_pkg::*;
#(
  parameter int W = SQR_W_DEFAULT
) (
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] mcand,
  input  logic [W-1:0]   mplier,
  output logic [2*W-1:0] acc_nxt,
  output logic [2*W-1:0] mcand_nxt,
  output logic [W-1:0]   mplier_nxt
);

  // Sum is 2W wide; the multiplicand never exceeds 2W bits after W shifts.
  always_comb begin : p_step
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
  end

endmodule
`default_nettype wire

// File: rtl/sqr_iter.sv
`default_nettype none
// ============================================================================
// Module   : sqr_iter
// Purpose  : Iterative shift-and-add squarer / multiplier, one multiplier bit
//            per clock, full 2W-bit product, valid/ready on both sides.
// Options  : SQR_ITER_EARLY_EXIT_EN - finish as soon as the remaining
//            multiplier bits are all zero (data-dependent latency).
// Revision : 1.0 - initial release
// ============================================================================
module sqr_iter
  import sqr_pkg::*;
#(
  parameter int W = SQR_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  sqr_iter_if.slave   bus
);

  localparam int CW = $clog2(W + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2*W-1:0]  r_acc;
  logic [2*W-1:0]  r_mcand;
  logic [W-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;

  logic [2*W-1:0]  w_acc_step;
  logic [2*W-1:0]  w_mcand_step;
  logic [W-1:0]    w_mplier_step;
  logic [W-1:0]    w_mplier_in;
  logic            w_last;

  assign w_mplier_in = bus.mul_mode ? bus.b : bus.a;

  shift_add_step #(.W(W)) u_step (
    .acc        (r_acc),
    .mcand      (r_mcand),
    .mplier     (r_mplier),
    .acc_nxt    (w_acc_step),
    .mcand_nxt  (w_mcand_step),
    .mplier_nxt (w_mplier_step)
  );

`ifdef SQR_ITER_EARLY_EXIT_EN
  // Leave CALC on the W-th step or once no set multiplier bits remain.
  assign w_last = (r_cnt == CW'(W - 1)) || (w_mplier_step == '0);
`else
  // Leave CALC on the W-th step regardless of operand value.
  assign w_last = (r_cnt == CW'(W - 1));
`endif

  // State register.
  always_ff @(posedge clk) begin : p_state
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; accept only from IDLE, handoff from DONE.
  always_comb begin : p_fsm_next
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef SQR_ITER_EARLY_EXIT_EN
          w_state_nxt = (w_mplier_in == '0) ? DONE : CALC;
`else
          w_state_nxt = CALC;
`endif
        end
      end
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands at accept, step while in CALC, hold in DONE.
  always_ff @(posedge clk) begin : p_datapath
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, bus.a};
            r_mplier <= w_mplier_in;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_acc_step;
          r_mcand  <= w_mcand_step;
          r_mplier <= w_mplier_step;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs come from state only; reset forces both quiet.
  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = (r_state == DONE) && !rst;
  assign bus.busy      = (r_state != IDLE);
  assign bus.product   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_sqr_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqr_iter
// Purpose  : Self-checking bench for sqr_iter: directed scenarios on a W=10
//            instance plus randomized streams on W = 4, 10 and 16 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqr_iter;
  import sqr_pkg::*;

  localparam int W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  bit   rand_go = 1'b0;

  always #5 clk = ~clk;

  sqr_iter_if #(.W(W)) bus ();
  sqr_iter #(.W(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  // Expected edges from accept edge (inclusive) until out_valid is seen.
  function automatic int exp_edges(input int mplier);
    int k;
`ifdef SQR_ITER_EARLY_EXIT_EN
    k = 0;
    while (mplier != 0) begin
      k++;
      mplier = mplier >> 1;
    end
`else
    k = W;
`endif
    return 1 + k;
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.mul_mode = mode;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.mul_mode = 1'($urandom);
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    while (!bus.out_valid && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b required 0/0", bus.in_ready, bus.out_valid);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: in_ready=%b out_valid=%b busy=%b required 1/0/0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    n_vec++;
    if (bus.product !== '0) begin
      n_err++;
      $display("FAIL reset_product: got %0d required 0", bus.product);
    end
  endtask

  task automatic test_single_op(input string name, input int a, input int b,
                                input logic mode, input longint exp_p);
    int edges;
    int e_exp;
    start_op(W'(a), W'(b), mode);
    e_exp = exp_edges(mode ? b : a);
    wait_done(edges);
    n_vec++;
    if (edges != e_exp) begin
      n_err++;
      $display("FAIL %s_latency: edges=%0d required %0d", name, edges, e_exp);
    end
    n_vec++;
    if (bus.out_valid !== 1'b1 || 64'(bus.product) !== 64'(exp_p)) begin
      n_err++;
      $display("FAIL %s_product: out_valid=%b got %0d required %0d", name, bus.out_valid, bus.product, exp_p);
    end
    take();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_handoff: out_valid=%b in_ready=%b required 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_directed();
    test_single_op("square_max", 1023, 0, 1'b0, 1046529);
    test_single_op("mul_small_b", 1000, 3, 1'b1, 3000);
    test_single_op("square_zero", 0, 0, 1'b0, 0);
    test_single_op("mul_b_zero", 777, 0, 1'b1, 0);
    test_single_op("square_one", 1, 0, 1'b0, 1);
  endtask

  task automatic test_random_latency();
    int a, b;
    logic mode;
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(0, 1023));
      mode = 1'($urandom);
      test_single_op("rand_op", a, b, mode, mode ? longint'(a) * b : longint'(a) * a);
    end
  endtask

  task automatic test_backpressure();
    int edges;
    start_op(W'(5), W'(0), 1'b0);
    wait_done(edges);
    bus.in_valid = 1'b1; bus.a = W'(7); bus.b = W'(0); bus.mul_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.product !== 20'd25 || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold: cycle %0d out_valid=%b product=%0d in_ready=%b required 1/25/0",
                 i, bus.out_valid, bus.product, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b busy=%b required 0/1/0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_next_accept: busy=%b in_ready=%b required 1/0", bus.busy, bus.in_ready);
    end
    wait_done(edges);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.product !== 20'd49) begin
      n_err++;
      $display("FAIL stall_next_product: out_valid=%b got %0d required 49", bus.out_valid, bus.product);
    end
    take();
  endtask

  task automatic test_reset_mid_calc();
    start_op(W'(511), W'(0), 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_hold: in_ready=%b out_valid=%b required 0/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.product !== '0) begin
      n_err++;
      $display("FAIL midrst_after: out_valid=%b in_ready=%b busy=%b product=%0d required 0/1/0/0",
               bus.out_valid, bus.in_ready, bus.busy, bus.product);
    end
    test_single_op("after_rst", 3, 0, 1'b0, 9);
  endtask

  task automatic test_back_to_back();
    int c;
    c = 0;
    rand_go = 1'b1;
    while (n_done < 3 && c < 45000) begin
      @(posedge clk);
      c++;
    end
    n_vec++;
    if (n_done != 3) begin
      n_err++;
      $display("FAIL b2b_timeout: streams finished=%0d required 3", n_done);
    end
  endtask

  // Randomized streams with stalls on three widths, scoreboarded in order.
  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int WI   = (gi == 0) ? 4 : (gi == 1) ? 10 : 16;
    localparam int NOPS = (gi == 0) ? 334 : 333;

    sqr_iter_if #(.W(WI)) rb ();
    sqr_iter #(.W(WI)) u_rdut (.clk(clk), .rst(rst), .bus(rb));

    initial begin : p_rand
      logic [63:0] q[$];
      logic [63:0] exp_p;
      int sent, recv, cyc;
      rb.in_valid = 1'b0; rb.out_ready = 1'b0;
      rb.a = '0; rb.b = '0; rb.mul_mode = 1'b0;
      sent = 0; recv = 0; cyc = 0;
      wait (rand_go);
      while (recv < NOPS && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        if (sent < NOPS && $urandom_range(0, 3) != 0) begin
          rb.in_valid = 1'b1;
          rb.a = WI'($urandom); rb.b = WI'($urandom); rb.mul_mode = 1'($urandom);
        end else begin
          rb.in_valid = 1'b0;
        end
        rb.out_ready = ($urandom_range(0, 3) != 0);
        if (rb.in_valid && rb.in_ready) begin
          q.push_back(sqr_ref(32'(rb.a), 32'(rb.b), rb.mul_mode));
          sent++;
        end
        if (rb.out_valid && rb.out_ready) begin
          n_vec++;
          recv++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL b2b_w%0d_dup: product %0d with nothing outstanding", WI, rb.product);
          end else begin
            exp_p = q.pop_front();
            if (64'(rb.product) !== exp_p) begin
              n_err++;
              $display("FAIL b2b_w%0d_product: got %0d required %0d", WI, rb.product, exp_p);
            end
          end
        end
      end
      rb.in_valid = 1'b0;
      rb.out_ready = 1'b1;
      n_vec++;
      if (recv < NOPS) begin
        n_err++;
        $display("FAIL b2b_w%0d_count: received %0d required %0d", WI, recv, NOPS);
      end
      repeat (WI + 4) @(negedge clk);
      n_vec++;
      if (rb.out_valid !== 1'b0 || q.size() != 0) begin
        n_err++;
        $display("FAIL b2b_w%0d_leftover: out_valid=%b outstanding=%0d required 0/0",
                 WI, rb.out_valid, q.size());
      end
      n_done++;
    end
  end

  initial begin : p_main
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.mul_mode = 1'b0;
    test_reset();
    test_directed();
    test_random_latency();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
